// File: rtl/tuner_ctrl.sv
// tuner_ctrl -- host-side controller for one tuner_phy instance.
//
// A start command triggers a ring sweep on the PHY and captures the returned
// peak list. The controller then selects the entry at the target index
// latched with start, programs the PHY lock target (power and tune code) and
// triggers lock. While locked it acknowledges lock-loss interrupts and
// requests resume after RESUME_WAIT cycles of back-off. If the selected index
// is beyond the returned peak count, the search is repeated. After MAX_RETRY
// failed searches the controller parks in ERR.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_start, i_abort          command pulses (start: IDLE only; abort: LOCKED/ERR only)
//   i_target_idx              peak index to lock onto, sampled with start
//   o_search_trig_val/rdy     search request handshake
//   i_search_peaks_val/rdy    peak list handshake (+ tune/power arrays, count)
//   o_lock_trig_val/rdy       lock request handshake
//   i_lock_intr_val/rdy       lock-loss interrupt handshake
//   o_lock_resume_val/rdy     resume request handshake
//   o_cfg_pwr_peak            lock target power to the PHY
//   o_cfg_ring_tune_peak      lock start tune code to the PHY
//   o_state, o_locked, o_err  status monitors
//   o_retry_cnt, o_intr_cnt   failed searches / accepted interrupts since start
//
// All val/rdy outputs are decoded from the state register. The only input
// that reaches an output combinationally is i_abort, which masks
// o_lock_intr_rdy so that an abort always wins over a pending interrupt.

module tuner_ctrl #(
  parameter int DAC_WIDTH   = 8,
  parameter int ADC_WIDTH   = 8,
  parameter int NUM_TARGET  = 8,
  parameter int MAX_RETRY   = 3,
  parameter int RESUME_WAIT = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_start,
  input  logic                                  i_abort,
  input  logic [$clog2(NUM_TARGET)-1:0]         i_target_idx,
  output logic                                  o_search_trig_val,
  input  logic                                  i_search_trig_rdy,
  input  logic                                  i_search_peaks_val,
  output logic                                  o_search_peaks_rdy,
  input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]  i_ring_tune_peaks,
  input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]  i_pwr_peaks,
  input  logic [$clog2(NUM_TARGET):0]           i_peaks_cnt,
  output logic                                  o_lock_trig_val,
  input  logic                                  i_lock_trig_rdy,
  input  logic                                  i_lock_intr_val,
  output logic                                  o_lock_intr_rdy,
  output logic                                  o_lock_resume_val,
  input  logic                                  i_lock_resume_rdy,
  output logic [ADC_WIDTH-1:0]                  o_cfg_pwr_peak,
  output logic [DAC_WIDTH-1:0]                  o_cfg_ring_tune_peak,
  output logic [3:0]                            o_state,
  output logic                                  o_locked,
  output logic                                  o_err,
  output logic [$clog2(MAX_RETRY+1)-1:0]        o_retry_cnt,
  output logic [7:0]                            o_intr_cnt
);

  localparam int IW = $clog2(NUM_TARGET);
  localparam int RW = $clog2(MAX_RETRY+1);
  localparam int BW = (RESUME_WAIT > 1) ? $clog2(RESUME_WAIT) : 1;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    SEARCH_REQ  = 4'd1,
    SEARCH_WAIT = 4'd2,
    SELECT      = 4'd3,
    LOCK_REQ    = 4'd4,
    LOCKED      = 4'd5,
    BACKOFF     = 4'd6,
    RESUME_REQ  = 4'd7,
    ERR         = 4'd8
  } state_t;

  // One peak-list entry: what gets handed to the PHY as lock target.
  typedef struct packed {
    logic [ADC_WIDTH-1:0] pwr;
    logic [DAC_WIDTH-1:0] tune;
  } peak_t;

  state_t        state, state_nxt;
  logic [IW-1:0] tgt_idx;
  logic [IW:0]   cnt_q;
  peak_t         cap_q;     // entry captured at the peak handshake
  peak_t         cfg_q;     // entry currently programmed into the PHY
  logic [BW-1:0] bo_cnt;

  logic          sel_ok;
  logic [RW-1:0] retry_inc;
  logic          retry_max;
  logic          intr_take;

  // Selection succeeds when the latched index lies inside the returned list.
  assign sel_ok    = ({1'b0, tgt_idx} < cnt_q);
  assign retry_inc = o_retry_cnt + RW'(1);
  assign retry_max = (retry_inc == RW'(MAX_RETRY));
  assign intr_take = (state == LOCKED) && !i_abort && i_lock_intr_val;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt          = state;
    o_search_trig_val  = 1'b0;
    o_search_peaks_rdy = 1'b0;
    o_lock_trig_val    = 1'b0;
    o_lock_intr_rdy    = 1'b0;
    o_lock_resume_val  = 1'b0;
    o_locked           = 1'b0;
    o_err              = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) state_nxt = SEARCH_REQ;
      end
      SEARCH_REQ: begin
        o_search_trig_val = 1'b1;
        if (i_search_trig_rdy) state_nxt = SEARCH_WAIT;
      end
      SEARCH_WAIT: begin
        o_search_peaks_rdy = 1'b1;
        if (i_search_peaks_val) state_nxt = SELECT;
      end
      SELECT: begin
        if (sel_ok)         state_nxt = LOCK_REQ;
        else if (retry_max) state_nxt = ERR;
        else                state_nxt = SEARCH_REQ;
      end
      LOCK_REQ: begin
        o_lock_trig_val = 1'b1;
        if (i_lock_trig_rdy) state_nxt = LOCKED;
      end
      LOCKED: begin
        o_locked        = 1'b1;
        // Abort takes priority; withholding rdy keeps the interrupt pending
        // at the PHY rather than silently dropping it.
        o_lock_intr_rdy = !i_abort;
        if (i_abort)              state_nxt = IDLE;
        else if (i_lock_intr_val) state_nxt = BACKOFF;
      end
      BACKOFF: begin
        if (bo_cnt == '0) state_nxt = RESUME_REQ;
      end
      RESUME_REQ: begin
        o_lock_resume_val = 1'b1;
        if (i_lock_resume_rdy) state_nxt = LOCKED;
      end
      ERR: begin
        o_err = 1'b1;
        if (i_abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_state = state;

  // ---------------------------------------------------------------------------
  // Datapath: target latch, peak capture, lock config, counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tgt_idx     <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
      cfg_q       <= '0;
      o_retry_cnt <= '0;
      o_intr_cnt  <= '0;
      bo_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            tgt_idx     <= i_target_idx;
            o_retry_cnt <= '0;
            o_intr_cnt  <= '0;
          end
        end
        SEARCH_WAIT: begin
          // Only the entry at the latched index is kept; the rest of the
          // list is never needed after selection.
          if (i_search_peaks_val) begin
            cnt_q      <= i_peaks_cnt;
            cap_q.tune <= i_ring_tune_peaks[tgt_idx];
            cap_q.pwr  <= i_pwr_peaks[tgt_idx];
          end
        end
        SELECT: begin
          if (sel_ok) cfg_q       <= cap_q;
          else        o_retry_cnt <= retry_inc;
        end
        LOCKED: begin
          if (intr_take) begin
            if (o_intr_cnt != 8'hFF) o_intr_cnt <= o_intr_cnt + 8'd1;
            // Loaded with WAIT-1 so BACKOFF lasts exactly RESUME_WAIT cycles
            // (terminal count 0 included).
            bo_cnt <= BW'(RESUME_WAIT - 1);
          end
        end
        BACKOFF: begin
          if (bo_cnt != '0) bo_cnt <= bo_cnt - BW'(1);
        end
        default: ;
      endcase
    end
  end

  // cfg_q only changes in SELECT, so it is stable through LOCK_REQ and the
  // whole locked loop.
  assign o_cfg_pwr_peak       = cfg_q.pwr;
  assign o_cfg_ring_tune_peak = cfg_q.tune;

endmodule

// File: tb/tb_tuner_ctrl.sv
// Self-checking bench for tuner_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle
// against a behavioural model that tracks the controller's phase, counters
// and a timestamp for when resume becomes due.

module tb_tuner_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NT = 8;
  localparam int MR = 3;
  localparam int RWAIT = 16;
  localparam int IW = $clog2(NT);

  localparam int P_IDLE = 0, P_SREQ = 1, P_SWAIT = 2, P_SEL = 3, P_LREQ = 4,
                 P_LOCKED = 5, P_BACK = 6, P_RREQ = 7, P_ERR = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start, abort;
  logic [IW-1:0] target;
  logic search_rdy, peaks_val, lock_rdy, intr_val, resume_rdy;
  logic [NT-1:0][DW-1:0] tune_arr;
  logic [NT-1:0][AW-1:0] pwr_arr;
  logic [IW:0] peaks_cnt;

  logic o_search_trig_val, o_search_peaks_rdy, o_lock_trig_val;
  logic o_lock_intr_rdy, o_lock_resume_val, o_locked, o_err;
  logic [AW-1:0] o_cfg_pwr_peak;
  logic [DW-1:0] o_cfg_ring_tune_peak;
  logic [3:0] o_state;
  logic [$clog2(MR+1)-1:0] o_retry_cnt;
  logic [7:0] o_intr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tuner_ctrl #(
    .DAC_WIDTH(DW), .ADC_WIDTH(AW), .NUM_TARGET(NT),
    .MAX_RETRY(MR), .RESUME_WAIT(RWAIT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_target_idx(target),
    .o_search_trig_val(o_search_trig_val), .i_search_trig_rdy(search_rdy),
    .i_search_peaks_val(peaks_val), .o_search_peaks_rdy(o_search_peaks_rdy),
    .i_ring_tune_peaks(tune_arr), .i_pwr_peaks(pwr_arr), .i_peaks_cnt(peaks_cnt),
    .o_lock_trig_val(o_lock_trig_val), .i_lock_trig_rdy(lock_rdy),
    .i_lock_intr_val(intr_val), .o_lock_intr_rdy(o_lock_intr_rdy),
    .o_lock_resume_val(o_lock_resume_val), .i_lock_resume_rdy(resume_rdy),
    .o_cfg_pwr_peak(o_cfg_pwr_peak), .o_cfg_ring_tune_peak(o_cfg_ring_tune_peak),
    .o_state(o_state), .o_locked(o_locked), .o_err(o_err),
    .o_retry_cnt(o_retry_cnt), .o_intr_cnt(o_intr_cnt)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_ph = P_IDLE;
  int m_idx = 0, m_cnt = 0, m_tune = 0, m_pwr = 0;
  int m_ctune = 0, m_cpwr = 0, m_retry = 0, m_intr = 0;
  longint edge_n = 0, m_due = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= P_IDLE; m_idx <= 0; m_cnt <= 0; m_tune <= 0; m_pwr <= 0;
      m_ctune <= 0; m_cpwr <= 0; m_retry <= 0; m_intr <= 0;
    end else begin
      edge_n <= edge_n + 1;
      case (m_ph)
        P_IDLE:  if (start) begin
                   m_retry <= 0; m_intr <= 0; m_idx <= int'(target); m_ph <= P_SREQ;
                 end
        P_SREQ:  if (search_rdy) m_ph <= P_SWAIT;
        P_SWAIT: if (peaks_val) begin
                   m_cnt  <= int'(peaks_cnt);
                   m_tune <= int'(tune_arr[m_idx]);
                   m_pwr  <= int'(pwr_arr[m_idx]);
                   m_ph   <= P_SEL;
                 end
        P_SEL:   if (m_cnt > m_idx) begin
                   m_ctune <= m_tune; m_cpwr <= m_pwr; m_ph <= P_LREQ;
                 end else begin
                   m_retry <= m_retry + 1;
                   m_ph    <= (m_retry + 1 == MR) ? P_ERR : P_SREQ;
                 end
        P_LREQ:  if (lock_rdy) m_ph <= P_LOCKED;
        P_LOCKED: if (abort) m_ph <= P_IDLE;
                  else if (intr_val) begin
                    m_intr <= (m_intr < 255) ? m_intr + 1 : 255;
                    m_due  <= edge_n + RWAIT;   // resume state follows this edge
                    m_ph   <= P_BACK;
                  end
        P_BACK:  if (edge_n == m_due) m_ph <= P_RREQ;
        P_RREQ:  if (resume_rdy) m_ph <= P_LOCKED;
        P_ERR:   if (abort) m_ph <= P_IDLE;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison, mid-cycle (inputs change 2 units after posedge).
  always @(negedge clk) begin
    chk("state",           int'(o_state),              m_ph);
    chk("search_trig_val", int'(o_search_trig_val),    int'(m_ph == P_SREQ));
    chk("peaks_rdy",       int'(o_search_peaks_rdy),   int'(m_ph == P_SWAIT));
    chk("lock_trig_val",   int'(o_lock_trig_val),      int'(m_ph == P_LREQ));
    chk("intr_rdy",        int'(o_lock_intr_rdy),      int'(m_ph == P_LOCKED && !abort));
    chk("resume_val",      int'(o_lock_resume_val),    int'(m_ph == P_RREQ));
    chk("locked",          int'(o_locked),             int'(m_ph == P_LOCKED));
    chk("err",             int'(o_err),                int'(m_ph == P_ERR));
    chk("cfg_tune",        int'(o_cfg_ring_tune_peak), m_ctune);
    chk("cfg_pwr",         int'(o_cfg_pwr_peak),       m_cpwr);
    chk("retry_cnt",       int'(o_retry_cnt),          m_retry);
    chk("intr_cnt",        int'(o_intr_cnt),           m_intr);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    start = 1'b0; abort = 1'b0; target = '0;
    search_rdy = 1'b0; peaks_val = 1'b0; lock_rdy = 1'b0;
    intr_val = 1'b0; resume_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, dup;
    idle_in();
    tune_arr = '0; pwr_arr = '0; peaks_cnt = '0;
    #1 rst = 1'b1;
    step(); step();

    // Reset state
    chk("rst_state", int'(o_state), 0);
    chk("rst_search_val", int'(o_search_trig_val), 0);
    chk("rst_lock_val", int'(o_lock_trig_val), 0);
    chk("rst_cfg_tune", int'(o_cfg_ring_tune_peak), 0);
    chk("rst_retry", int'(o_retry_cnt), 0);
    rst = 1'b0;
    step();

    // Nominal lock onto index 1
    target = 3'd1; start = 1'b1; step(); start = 1'b0;
    chk("nom_search_val", int'(o_search_trig_val), 1);
    search_rdy = 1'b1; step(); search_rdy = 1'b0;
    tune_arr[0] = 8'd40;  tune_arr[1] = 8'd90;  tune_arr[2] = 8'd200;
    pwr_arr[0]  = 8'd120; pwr_arr[1]  = 8'd180; pwr_arr[2]  = 8'd60;
    peaks_cnt = 4'd3; peaks_val = 1'b1; step(); peaks_val = 1'b0;
    chk("nom_select", int'(o_state), 3);
    step();
    chk("nom_cfg_tune", int'(o_cfg_ring_tune_peak), 90);
    chk("nom_cfg_pwr", int'(o_cfg_pwr_peak), 180);
    chk("nom_model_tune", m_ctune, 90);
    chk("nom_lock_val", int'(o_lock_trig_val), 1);
    lock_rdy = 1'b1; step(); lock_rdy = 1'b0;
    chk("nom_locked", int'(o_locked), 1);

    // Interrupt, back-off, resume with 5 cycles of backpressure
    intr_val = 1'b1; step(); intr_val = 1'b0;
    k = 0;
    while (!o_lock_resume_val && k < 40) begin step(); k++; end
    chk("resume_latency", k + 1, 17);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_lock_resume_val) n++;
      step();
    end
    resume_rdy = 1'b1;
    if (o_lock_resume_val) n++;
    step(); resume_rdy = 1'b0;
    chk("resume_hold", n, 6);
    chk("resume_locked", int'(o_locked), 1);
    chk("resume_intr_cnt", int'(o_intr_cnt), 1);

    // Abort and interrupt together: abort wins
    abort = 1'b1; intr_val = 1'b1;
    #1 chk("abort_intr_rdy", int'(o_lock_intr_rdy), 0);
    step(); abort = 1'b0; intr_val = 1'b0;
    chk("abort_state", int'(o_state), 0);
    chk("abort_intr_cnt", int'(o_intr_cnt), 1);

    // Index 2 never inside a 2-entry list: retry until error
    target = 3'd2; start = 1'b1; step(); start = 1'b0;
    search_rdy = 1'b1; peaks_val = 1'b1; peaks_cnt = 4'd2;
    n = 0;
    for (k = 0; k < 60 && !o_err; k++) begin
      if (o_search_trig_val) n++;
      step();
    end
    search_rdy = 1'b0; peaks_val = 1'b0;
    chk("retry_triggers", n, 3);
    chk("retry_cnt_final", int'(o_retry_cnt), 3);
    chk("retry_model", m_retry, 3);
    chk("retry_err", int'(o_err), 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("err_abort_err", int'(o_err), 0);
    chk("err_abort_state", int'(o_state), 0);

    // Backpressure on search trigger and on the peak list
    target = 3'd0; start = 1'b1; step(); start = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_search_trig_val) n++;
      step();
    end
    chk("bp_trig_held", n, 10);
    search_rdy = 1'b1; step(); search_rdy = 1'b0;
    n = 0; dup = 0;
    for (int i = 0; i < 50; i++) begin
      start = (i == 20);
      if (o_search_peaks_rdy) n++;
      if (o_search_trig_val) dup++;
      step();
    end
    start = 1'b0;
    chk("bp_peaks_rdy_held", n, 50);
    chk("bp_dup_trig", dup, 0);
    tune_arr[0] = 8'd77; pwr_arr[0] = 8'd33; peaks_cnt = 4'd1; peaks_val = 1'b1;
    n = 0;
    if (o_search_peaks_rdy) n++;
    step(); peaks_val = 1'b0;
    if (o_search_peaks_rdy) n++;
    chk("bp_capture_once", n, 1);
    step();
    chk("bp_cfg_tune", int'(o_cfg_ring_tune_peak), 77);
    chk("bp_cfg_pwr", int'(o_cfg_pwr_peak), 33);
    chk("bp_lock_val", int'(o_lock_trig_val), 1);

    // Async reset in LOCK_REQ takes effect before the next edge
    rst = 1'b1;
    #1;
    chk("arst_lock_val", int'(o_lock_trig_val), 0);
    chk("arst_cfg_tune", int'(o_cfg_ring_tune_peak), 0);
    chk("arst_cfg_pwr", int'(o_cfg_pwr_peak), 0);
    chk("arst_state", int'(o_state), 0);
    step(); rst = 1'b0; step();

    // Interrupt counter saturation
    target = 3'd0; start = 1'b1; step(); start = 1'b0;
    search_rdy = 1'b1; peaks_val = 1'b1; peaks_cnt = 4'd1;
    lock_rdy = 1'b1; intr_val = 1'b1; resume_rdy = 1'b1;
    n = 0;
    for (k = 0; k < 6000 && n < 260; k++) begin
      if (o_lock_intr_rdy && intr_val) n++;
      step();
    end
    intr_val = 1'b0;
    chk("sat_handshakes", n, 260);
    chk("sat_intr_cnt", int'(o_intr_cnt), 255);
    chk("sat_model", m_intr, 255);
    for (k = 0; k < 40 && !o_locked; k++) step();
    idle_in(); abort = 1'b1; step(); abort = 1'b0;
    chk("sat_abort_state", int'(o_state), 0);

    // Randomized traffic, checked by the per-cycle model comparison
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 9) == 0);
      target     = IW'($urandom_range(0, NT - 1));
      search_rdy = 1'($urandom_range(0, 1));
      peaks_val  = 1'($urandom_range(0, 1));
      peaks_cnt  = (IW+1)'($urandom_range(0, NT));
      for (int j = 0; j < NT; j++) begin
        tune_arr[j] = DW'($urandom_range(0, 255));
        pwr_arr[j]  = AW'($urandom_range(0, 255));
      end
      lock_rdy   = 1'($urandom_range(0, 1));
      intr_val   = ($urandom_range(0, 3) == 0);
      resume_rdy = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; idle_in();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
